// File: rtl/fetch_queue_pkg.sv
// Shared core types for the fetch queue: word typedefs, the queued entry
// layout and the default queue depth.
package fetch_queue_pkg;

  typedef logic [15:0] w16;
  typedef logic [31:0] w32;

  localparam int unsigned FQ_DEPTH_DEFAULT = 4;

  typedef struct packed {
    w32   instr;
    w16   pc;
    logic approx;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_ram.sv
// Entry storage for the fetch queue: DEPTH registers, one write port,
// one asynchronous read port and an asynchronous active-low clear.
module fetch_queue_ram
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = FQ_DEPTH_DEFAULT,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         we_i,
  input  logic [AW-1:0] waddr_i,
  input  fetch_entry_t wdata_i,
  input  logic [AW-1:0] raddr_i,
  output fetch_entry_t rdata_o
);

  fetch_entry_t mem_q [DEPTH];

  // Entry array: cleared on reset, otherwise written one slot per push.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q <= '{default: '0};
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end else begin
      mem_q <= mem_q;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction queue: handshake, pointers and occupancy
// control around the fetch_queue_ram storage.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = FQ_DEPTH_DEFAULT
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_en,
  output logic                       in_reject,
  input  logic [31:0]                in_instr,
  input  logic [15:0]                in_pc,
  input  logic                       in_approx,
  input  logic                       flush,
  output logic                       out_en,
  input  logic                       out_reject,
  output logic [31:0]                out_instr,
  output logic [15:0]                out_pc,
  output logic                       out_approx,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_s, pop_s;
  fetch_entry_t  wr_entry_s, head_entry_s;

  // Full-reject never looks at out_reject, so a same-cycle pop cannot open a slot.
  assign in_reject = (count_q == CW'(DEPTH)) | ~reset;
  assign out_en    = (count_q != '0) & ~flush;

  assign push_s = in_en & ~in_reject & ~flush;
  assign pop_s  = out_en & ~out_reject;

  assign wr_entry_s = '{instr: in_instr, pc: in_pc, approx: in_approx};

  // Next-state for pointers and occupancy; flush discards everything.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      count_d = count_q + CW'(push_s) - CW'(pop_s);
    end
  end

  // Control state registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  fetch_queue_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk_i   (clock),
    .rst_ni  (reset),
    .we_i    (push_s),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_entry_s),
    .raddr_i (rd_ptr_q),
    .rdata_o (head_entry_s)
  );

  assign out_instr  = head_entry_s.instr;
  assign out_pc     = head_entry_s.pc;
  assign out_approx = head_entry_s.approx;
  assign count      = count_q;

endmodule
